alu_seg_disp: RTL and testbench

- Downstream consumer of the 4-bit ALU stage. Captures ALU result and flags on a load strobe and drives three active-low 7-segment digits on the board: result, sign and flags.
- Formats the result according to the operation code that produced it.
- Blinks the result digits while the captured overflow flag is set.

---
 rtl/alu_disp_if.sv | 42 ++++
 rtl/alu_seg_disp.sv | 180 ++++++++++++++++++
 tb/tb_alu_seg_disp.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_disp_if.sv
// alu_disp_if: capture bus and digit outputs of alu_seg_disp.
// ALU_DISP_SCAN_EN adds the multiplexed seg_bus/an pair.
interface alu_disp_if;
  logic       load;
  logic       clr;
  logic [2:0] ctrl;
  logic [3:0] res;
  logic       car;
  logic       of;
  logic [7:0] seg_res;
  logic [7:0] seg_sign;
  logic [7:0] seg_flag;
  logic       busy_blink;
`ifdef ALU_DISP_SCAN_EN
  logic [7:0] seg_bus;
  logic [2:0] an;

  modport master (
    output load, clr, ctrl, res, car, of,
    input  seg_res, seg_sign, seg_flag,
    input  busy_blink, seg_bus, an
  );

  modport slave (
    input  load, clr, ctrl, res, car, of,
    output seg_res, seg_sign, seg_flag,
    output busy_blink, seg_bus, an
  );
`else
  modport master (
    output load, clr, ctrl, res, car, of,
    input  seg_res, seg_sign, seg_flag,
    input  busy_blink
  );

  modport slave (
    input  load, clr, ctrl, res, car, of,
    output seg_res, seg_sign, seg_flag,
    output busy_blink
  );
`endif
endinterface

// File: rtl/alu_seg_disp.sv
// alu_seg_disp: captures ALU result/flags, drives 7-seg digits.
// ALU_DISP_SCAN_EN adds a scanned seg_bus/an output.
module alu_seg_disp #(
  parameter logic [23:0] BLINK_DIV = 24'd5000000
`ifdef ALU_DISP_SCAN_EN
  ,
  parameter logic [15:0] SCAN_DIV  = 16'd1000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_disp_if.slave   bus
);

  localparam logic [7:0] BLANK = 8'hFF;
  localparam logic [7:0] MINUS = 8'hBF;

  typedef enum logic [1:0] {
    EMPTY,
    SHOW,
    BLINK_ON,
    BLINK_OFF
  } state_t;

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [2:0]  c_ctrl;
  logic [3:0]  c_res;
  logic        c_car;
  logic        c_of;
  logic [3:0]  mag;
  logic [7:0]  digit;
  logic [7:0]  sign;
  logic [7:0]  flag;
  logic        vis;
  logic        lit;

  function automatic logic [7:0] hex7(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  // state and blink counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // capture ALU result on load; clr takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_ctrl <= '0;
      c_res  <= '0;
      c_car  <= 1'b0;
      c_of   <= 1'b0;
    end else if (bus.load && !bus.clr) begin
      c_ctrl <= bus.ctrl;
      c_res  <= bus.res;
      c_car  <= bus.car;
      c_of   <= bus.of;
    end
  end

  // next state: clr, then load, then blink toggling
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (bus.clr) begin
      state_n = EMPTY;
      cnt_n   = '0;
    end else if (bus.load) begin
      state_n = bus.of ? BLINK_ON : SHOW;
      cnt_n   = '0;
    end else begin
      unique case (state)
        BLINK_ON, BLINK_OFF: begin
          if (cnt == BLINK_DIV - 24'd1) begin
            cnt_n   = '0;
            state_n = (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
          end else begin
            cnt_n = cnt + 24'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // format captured result by op class
  always_comb begin
    sign  = BLANK;
    mag   = c_res[3] ? (~c_res + 4'd1) : c_res;
    unique case (c_ctrl)
      3'b000, 3'b001: begin
        digit = hex7(mag);
        sign  = c_res[3] ? MINUS : BLANK;
      end
      3'b110, 3'b111: digit = hex7({3'b000, c_res[0]});
      default:        digit = hex7(c_res);
    endcase
  end

  // flag digit from captured carry/overflow
  always_comb begin
    unique case (1'b1)
      (c_car & c_of):  flag = 8'h23;
      (c_car & ~c_of): flag = 8'hC6;
      (~c_car & c_of): flag = 8'hA3;
      default:         flag = BLANK;
    endcase
  end

  assign vis = (state == SHOW) || (state == BLINK_ON);
  assign lit = (state != EMPTY);

  assign bus.seg_res    = vis ? digit : BLANK;
  assign bus.seg_sign   = vis ? sign : BLANK;
  assign bus.seg_flag   = lit ? flag : BLANK;
  assign bus.busy_blink = (state == BLINK_ON) || (state == BLINK_OFF);

`ifdef ALU_DISP_SCAN_EN
  logic [15:0] scnt;
  logic [1:0]  slot;

  // digit scan: advance slot every SCAN_DIV cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= '0;
      slot <= 2'd0;
    end else if (scnt == SCAN_DIV - 16'd1) begin
      scnt <= '0;
      slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
    end else begin
      scnt <= scnt + 16'd1;
    end
  end

  // route selected digit onto the shared bus
  always_comb begin
    unique case (slot)
      2'd1: begin
        bus.an      = 3'b101;
        bus.seg_bus = bus.seg_sign;
      end
      2'd2: begin
        bus.an      = 3'b011;
        bus.seg_bus = bus.seg_flag;
      end
      default: begin
        bus.an      = 3'b110;
        bus.seg_bus = bus.seg_res;
      end
    endcase
  end
`endif

endmodule

// File: tb/tb_alu_seg_disp.sv
// tb_alu_seg_disp: table, directed and random checks of alu_seg_disp.
// Reference model derives digits from arithmetic on the captured values.
module tb_alu_seg_disp;

  localparam int BD = 4;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cmp = 0;
  int   bad = 0;
  int   n = 0;

  alu_disp_if bus ();

`ifdef ALU_DISP_SCAN_EN
  alu_seg_disp #(.BLINK_DIV(24'd4), .SCAN_DIV(16'd2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`else
  alu_seg_disp #(.BLINK_DIV(24'd4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else n <= n + 1;
  end

  logic [7:0] font [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  bit         m_empty = 1;
  logic [2:0] m_ctrl;
  logic [3:0] m_res;
  logic       m_car, m_of;
  int         m_t;

  typedef struct {
    logic [2:0] ctrl;
    logic [3:0] res;
    logic       car;
    logic       of;
    logic [7:0] er;
    logic [7:0] es;
    logic [7:0] ef;
    logic       eb;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [7:0] a,
                     input logic [7:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic model_exp(output logic [7:0] r, output logic [7:0] s,
                           output logic [7:0] f, output logic b);
    int v;
    bit vis;
    r = 8'hFF; s = 8'hFF; f = 8'hFF; b = 1'b0;
    if (!m_empty) begin
      v = int'(m_res);
      if (m_ctrl <= 3'd1) begin
        if (v >= 8) begin
          v = 16 - v;
          s = 8'hBF;
        end
      end else if (m_ctrl >= 3'd6) begin
        v = v % 2;
      end
      r = font[v];
      if (m_car && m_of) f = 8'h23;
      else if (m_car) f = 8'hC6;
      else if (m_of) f = 8'hA3;
      b = m_of;
      vis = !m_of || ((m_t / BD) % 2 == 0);
      if (!vis) begin
        r = 8'hFF;
        s = 8'hFF;
      end
    end
  endtask

  task automatic check_model();
    logic [7:0] r, s, f;
    logic b;
    model_exp(r, s, f, b);
    chk("seg_res", bus.seg_res, r);
    chk("seg_sign", bus.seg_sign, s);
    chk("seg_flag", bus.seg_flag, f);
    chk("busy_blink", {7'd0, bus.busy_blink}, {7'd0, b});
`ifdef ALU_DISP_SCAN_EN
    begin
      int sl;
      sl = (n / SD) % 3;
      chk("seg_bus", bus.seg_bus, sl == 0 ? r : (sl == 1 ? s : f));
      chk("an", {5'd0, bus.an},
          {5'd0, sl == 0 ? 3'b110 : (sl == 1 ? 3'b101 : 3'b011)});
    end
`endif
  endtask

  task automatic cyc(input bit ld, input bit cl, input logic [2:0] c,
                     input logic [3:0] r, input logic ca, input logic o);
    bus.load = ld; bus.clr = cl; bus.ctrl = c;
    bus.res = r; bus.car = ca; bus.of = o;
    @(posedge clk);
    if (cl) m_empty = 1;
    else if (ld) begin
      m_empty = 0; m_ctrl = c; m_res = r;
      m_car = ca; m_of = o; m_t = 0;
    end else m_t++;
    #1;
    bus.load = 0; bus.clr = 0;
    check_model();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 3'd0, 4'd0, 0, 0);
  endtask

  task automatic chk_blank(input string nm);
    chk({nm, "_res"}, bus.seg_res, 8'hFF);
    chk({nm, "_sign"}, bus.seg_sign, 8'hFF);
    chk({nm, "_flag"}, bus.seg_flag, 8'hFF);
    chk({nm, "_busy"}, {7'd0, bus.busy_blink}, 8'd0);
  endtask

  initial begin
    tbl[0] = '{3'b000, 4'b1101, 1, 0, 8'hB0, 8'hBF, 8'hC6, 0};
    tbl[1] = '{3'b010, 4'hA,    0, 0, 8'h88, 8'hFF, 8'hFF, 0};
    tbl[2] = '{3'b111, 4'b0001, 0, 0, 8'hF9, 8'hFF, 8'hFF, 0};
    tbl[3] = '{3'b110, 4'b1110, 0, 0, 8'hC0, 8'hFF, 8'hFF, 0};
    tbl[4] = '{3'b001, 4'b0111, 0, 0, 8'hF8, 8'hFF, 8'hFF, 0};
    tbl[5] = '{3'b001, 4'b1000, 0, 1, 8'h80, 8'hBF, 8'hA3, 1};
    tbl[6] = '{3'b000, 4'b0000, 1, 1, 8'hC0, 8'hFF, 8'h23, 1};
    tbl[7] = '{3'b101, 4'hF,    0, 0, 8'h8E, 8'hFF, 8'hFF, 0};
    tbl[8] = '{3'b011, 4'h5,    0, 0, 8'h92, 8'hFF, 8'hFF, 0};
    tbl[9] = '{3'b100, 4'hC,    1, 0, 8'hC6, 8'hFF, 8'hC6, 0};

    bus.load = 0; bus.clr = 0; bus.ctrl = 0;
    bus.res = 0; bus.car = 0; bus.of = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk_blank("reset");
    idle(2);

    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, tbl[i].ctrl, tbl[i].res, tbl[i].car, tbl[i].of);
      chk($sformatf("tbl%0d_res", i), bus.seg_res, tbl[i].er);
      chk($sformatf("tbl%0d_sign", i), bus.seg_sign, tbl[i].es);
      chk($sformatf("tbl%0d_flag", i), bus.seg_flag, tbl[i].ef);
      chk($sformatf("tbl%0d_busy", i), {7'd0, bus.busy_blink},
          {7'd0, tbl[i].eb});
    end

    cyc(1, 0, 3'b000, 4'b1000, 0, 1);
    for (int i = 0; i < 8; i++) begin
      chk("blink_res", bus.seg_res, i < 4 ? 8'h80 : 8'hFF);
      chk("blink_sign", bus.seg_sign, i < 4 ? 8'hBF : 8'hFF);
      chk("blink_flag", bus.seg_flag, 8'hA3);
      chk("blink_busy", {7'd0, bus.busy_blink}, 8'd1);
      if (i < 7) idle(1);
    end

    cyc(1, 0, 3'b010, 4'hA, 0, 0);
    chk("reload_res", bus.seg_res, 8'h88);
    chk("reload_sign", bus.seg_sign, 8'hFF);
    chk("reload_busy", {7'd0, bus.busy_blink}, 8'd0);

    cyc(1, 0, 3'b111, 4'b0001, 0, 0);
    chk("cmp_res", bus.seg_res, 8'hF9);
    cyc(1, 1, 3'b011, 4'h5, 1, 1);
    chk_blank("collide");

    cyc(1, 0, 3'b011, 4'h5, 0, 0);
    idle(7);

    cyc(1, 0, 3'b000, 4'b1001, 1, 1);
    idle(2);
    #2 rst_n = 1'b0;
    #1 chk_blank("async_rst");
    m_empty = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk_blank("rst_release");
    idle(2);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(3) == 0, $urandom_range(15) == 0,
          3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
